cube_layer_shifter: RTL and testbench



---
 rtl/cube_pkg.sv | 22 ++
 rtl/cube_phase_timer.sv | 28 ++
 rtl/cube_layer_shifter.sv | 186 ++++++++++++++++++
 tb/tb_cube_layer_shifter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// Shared types, defaults and helpers for the LED cube layer shifter.
package cube_pkg;

  localparam int unsigned CUBE_LAYER_BITS = 64;
  localparam int unsigned CUBE_NUM_LAYERS = 8;
  // Widest layer-enable vector the onehot helper can build.
  localparam int unsigned CUBE_MAX_LAYERS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    DEAD  = 2'd3
  } cube_state_e;

  // One-hot layer enable; all zeros when idx is not below num.
  function automatic logic [CUBE_MAX_LAYERS-1:0] onehot(input int unsigned idx,
                                                        input int unsigned num);
    return (idx < num) ? (CUBE_MAX_LAYERS'(1) << idx) : '0;
  endfunction

endpackage

// File: rtl/cube_phase_timer.sv
// Loadable down-counter; o_tc_c is high while the count sits at zero.
// Loading value N yields an interval of N+1 cycles until the terminal-count edge.
module cube_phase_timer #(
  parameter int unsigned W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_tc_c
);

  logic [W-1:0] r_count;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_tc_c = (r_count == '0);

endmodule

// File: rtl/cube_layer_shifter.sv
// Serialises one cube layer into a 74HC595-style chain, latches it and
// switches the layer-enable transistors atomically.
// Optional: define CUBE_DEAD_TIME_EN to insert DEAD_CYCLES of blanking
// between the latch pulse and the new layer being enabled.
module cube_layer_shifter
  import cube_pkg::*;
#(
  parameter int unsigned LAYER_BITS  = CUBE_LAYER_BITS,
  parameter int unsigned NUM_LAYERS  = CUBE_NUM_LAYERS,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned DEAD_CYCLES = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          rst,
  input  logic [LAYER_BITS-1:0]         layer_data,
  input  logic [$clog2(NUM_LAYERS)-1:0] layer_idx,
  input  logic                          layer_valid,
  output logic                          layer_ready,
  output logic                          sr_data,
  output logic                          sr_clk,
  output logic                          sr_latch,
  output logic                          sr_oe_n,
  output logic [NUM_LAYERS-1:0]         layer_en,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned IDX_W = $clog2(NUM_LAYERS);
  localparam int unsigned BIT_W = $clog2(LAYER_BITS);
`ifdef CUBE_DEAD_TIME_EN
  localparam int unsigned TMR_MAX = (DEAD_CYCLES > CLK_DIV) ? DEAD_CYCLES : CLK_DIV;
`else
  localparam int unsigned TMR_MAX = CLK_DIV;
`endif
  localparam int unsigned TMR_W = $clog2(TMR_MAX + 1);

  // Reject parameter sets the timing scheme cannot express.
  if (CLK_DIV < 1 || DEAD_CYCLES < 1 || LAYER_BITS < 2 ||
      NUM_LAYERS < 2 || NUM_LAYERS > CUBE_MAX_LAYERS) begin : g_cfg_err
    $error("cube_layer_shifter: unsupported parameter set");
  end

  cube_state_e             r_state;
  logic [LAYER_BITS-1:0]   r_shadow;
  logic [IDX_W-1:0]        r_idx;
  logic [BIT_W-1:0]        r_bit_idx;
  logic                    r_primed;
  logic                    r_ready;
  logic                    r_sr_data;
  logic                    r_sr_clk;
  logic                    r_sr_latch;
  logic                    r_sr_oe_n;
  logic [NUM_LAYERS-1:0]   r_layer_en;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_hs;
  logic                    w_tc;
  logic                    w_tmr_load;
  logic [TMR_W-1:0]        w_tmr_value;
  logic [BIT_W-1:0]        w_bit_dec;

  assign w_hs       = (r_state == IDLE) && r_ready && layer_valid;
  assign w_tmr_load = w_hs || ((r_state != IDLE) && w_tc);
  assign w_bit_dec  = r_bit_idx - BIT_W'(1);

  // Length of the interval that starts on each timer load, chosen by the current state.
  always_comb begin
    w_tmr_value = '0;
    case (r_state)
      SHIFT:   w_tmr_value = TMR_W'(CLK_DIV - 1);
`ifdef CUBE_DEAD_TIME_EN
      LATCH:   w_tmr_value = TMR_W'(DEAD_CYCLES - 1);
`endif
      default: w_tmr_value = '0;
    endcase
  end

  cube_phase_timer #(
    .W (TMR_W)
  ) u_timer (
    .i_clk   (CLOCK_50),
    .i_rst   (rst),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_value),
    .o_tc_c  (w_tc)
  );

  // Main sequencer: capture, shift MSB first, latch, then commit the new layer.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shadow   <= '0;
      r_idx      <= '0;
      r_bit_idx  <= '0;
      r_primed   <= 1'b0;
      r_ready    <= 1'b0;
      r_sr_data  <= 1'b0;
      r_sr_clk   <= 1'b0;
      r_sr_latch <= 1'b0;
      r_sr_oe_n  <= 1'b1;
      r_layer_en <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_hs) begin
            r_shadow  <= layer_data;
            r_idx     <= layer_idx;
            r_bit_idx <= BIT_W'(LAYER_BITS - 1);
            r_primed  <= 1'b0;
            r_sr_clk  <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_tc) begin
            if (!r_primed) begin
              // One setup cycle after capture, then the first bit's low phase.
              r_primed  <= 1'b1;
              r_sr_data <= r_shadow[r_bit_idx];
            end else if (!r_sr_clk) begin
              r_sr_clk <= 1'b1;
            end else if (r_bit_idx == '0) begin
              r_sr_clk   <= 1'b0;
              r_sr_latch <= 1'b1;
              r_sr_oe_n  <= 1'b1;
              r_layer_en <= '0;
              r_state    <= LATCH;
            end else begin
              r_sr_clk  <= 1'b0;
              r_bit_idx <= w_bit_dec;
              r_sr_data <= r_shadow[w_bit_dec];
            end
          end
        end
        LATCH: begin
          if (w_tc) begin
            r_sr_latch <= 1'b0;
`ifdef CUBE_DEAD_TIME_EN
            r_state    <= DEAD;
`else
            r_sr_oe_n  <= 1'b0;
            r_layer_en <= NUM_LAYERS'(onehot(32'(r_idx), NUM_LAYERS));
            r_done     <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
`endif
          end
        end
`ifdef CUBE_DEAD_TIME_EN
        DEAD: begin
          if (w_tc) begin
            r_sr_oe_n  <= 1'b0;
            r_layer_en <= NUM_LAYERS'(onehot(32'(r_idx), NUM_LAYERS));
            r_done     <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
`endif
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign layer_ready = r_ready;
  assign sr_data     = r_sr_data;
  assign sr_clk      = r_sr_clk;
  assign sr_latch    = r_sr_latch;
  assign sr_oe_n     = r_sr_oe_n;
  assign layer_en    = r_layer_en;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_cube_layer_shifter.sv
// Directed bench for cube_layer_shifter (LAYER_BITS=8, CLK_DIV=2, DEAD_CYCLES=3).
module tb_cube_layer_shifter;

`ifdef CUBE_DEAD_TIME_EN
  localparam int EXP_LAT   = 38;
  localparam int EXP_BLANK = 5;
`else
  localparam int EXP_LAT   = 35;
  localparam int EXP_BLANK = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] data8, data6;
  logic [2:0] idx8, idx6;
  logic       valid8, valid6;
  logic       ready8, sd8, sc8, sl8, oe8, busy8, done8;
  logic       ready6, sd6, sc6, sl6, oe6, busy6, done6;
  logic [7:0] en8;
  logic [5:0] en6;

  cube_layer_shifter #(
    .LAYER_BITS(8), .NUM_LAYERS(8), .CLK_DIV(2), .DEAD_CYCLES(3)
  ) u_dut8 (
    .CLOCK_50(clk), .rst(rst), .layer_data(data8), .layer_idx(idx8),
    .layer_valid(valid8), .layer_ready(ready8), .sr_data(sd8), .sr_clk(sc8),
    .sr_latch(sl8), .sr_oe_n(oe8), .layer_en(en8), .busy(busy8), .done(done8)
  );

  cube_layer_shifter #(
    .LAYER_BITS(8), .NUM_LAYERS(6), .CLK_DIV(2), .DEAD_CYCLES(3)
  ) u_dut6 (
    .CLOCK_50(clk), .rst(rst), .layer_data(data6), .layer_idx(idx6),
    .layer_valid(valid6), .layer_ready(ready6), .sr_data(sd6), .sr_clk(sc6),
    .sr_latch(sl6), .sr_oe_n(oe6), .layer_en(en6), .busy(busy6), .done(done6)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe one dut8 operation from the cycle after its handshake up to done.
  task automatic run_op(input int corrupt_at, output logic [7:0] bits, output int rises,
                        output int done_at, output int latch_cnt, output int blank_cnt,
                        output int hold_bad, output int latch_bad);
    logic       prev_clk;
    logic       seen_latch;
    logic [7:0] en_before;
    bits = '0; rises = 0; done_at = -1; latch_cnt = 0; blank_cnt = 0;
    hold_bad = 0; latch_bad = 0; prev_clk = 1'b0; seen_latch = 1'b0;
    en_before = en8;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) tick();
      if (cyc == corrupt_at) data8 = 8'h00;
      if (sc8 && !prev_clk) begin
        bits = {bits[6:0], sd8};
        rises++;
      end
      prev_clk = sc8;
      if (sl8) begin
        seen_latch = 1'b1;
        latch_cnt++;
        if (en8 != 8'h00 || !oe8) latch_bad++;
      end
      if (!seen_latch && en8 != en_before) hold_bad++;
      if (seen_latch && oe8 && en8 == 8'h00) blank_cnt++;
      if (done8) begin
        done_at = cyc;
        break;
      end
    end
  endtask

  // Issue one dut6 layer and return cycles from handshake to done (-1 on timeout).
  task automatic run6(input logic [2:0] idx, output int lat);
    data6 = 8'hFF; idx6 = idx; valid6 = 1'b1;
    tick();
    valid6 = 1'b0;
    lat = -1;
    for (int cyc = 1; cyc < 200; cyc++) begin
      tick();
      if (done6) begin
        lat = cyc;
        break;
      end
    end
  endtask

  logic [7:0] bits;
  int rises, done_at, latch_cnt, blank_cnt, hold_bad, latch_bad, lat6, n_done;

  initial begin
    rst = 1'b1;
    data8 = '0; idx8 = '0; valid8 = 1'b0;
    data6 = '0; idx6 = '0; valid6 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_oe_n",   oe8,    1);
    check("rst_en",     en8,    0);
    check("rst_sr_clk", sc8,    0);
    check("rst_latch",  sl8,    0);
    check("rst_data",   sd8,    0);
    check("rst_ready",  ready8, 0);
    check("rst_busy",   busy8,  0);
    check("rst_done",   done8,  0);
    #2 rst = 1'b0;
    tick();
    check("rel_ready", ready8, 1);
    check("rel_busy",  busy8,  0);

    // Single layer A5 -> layer 3.
    data8 = 8'hA5; idx8 = 3'd3; valid8 = 1'b1;
    tick();
    valid8 = 1'b0;
    check("s1_busy", busy8, 1);
    run_op(-1, bits, rises, done_at, latch_cnt, blank_cnt, hold_bad, latch_bad);
    check("s1_bits",     bits,      8'hA5);
    check("s1_rises",    rises,     8);
    check("s1_latency",  done_at,   EXP_LAT);
    check("s1_latch",    latch_cnt, 2);
    check("s1_blank",    blank_cnt, EXP_BLANK);
    check("s1_latchbad", latch_bad, 0);
    check("s1_hold",     hold_bad,  0);
    check("s1_en",       en8,       8'b0000_1000);
    check("s1_oe_n",     oe8,       0);
    check("s1_ready",    ready8,    1);
    tick();
    check("s1_done_1cyc", done8, 0);
    check("s1_en_hold",   en8,   8'b0000_1000);

    // Input change mid-shift must not leak into the chain; layer 3 stays lit.
    data8 = 8'hA5; idx8 = 3'd3; valid8 = 1'b1;
    tick();
    valid8 = 1'b0;
    idx8 = 3'd6;
    run_op(5, bits, rises, done_at, latch_cnt, blank_cnt, hold_bad, latch_bad);
    check("s2_bits",    bits,     8'hA5);
    check("s2_hold",    hold_bad, 0);
    check("s2_latency", done_at,  EXP_LAT);
    check("s2_en",      en8,      8'b0000_1000);

    // Back-to-back: idx 0 then idx 7 with valid held high.
    data8 = 8'h5A; idx8 = 3'd0; valid8 = 1'b1;
    tick();
    idx8 = 3'd7; data8 = 8'hC3;
    run_op(-1, bits, rises, done_at, latch_cnt, blank_cnt, hold_bad, latch_bad);
    check("b2b1_bits",    bits,    8'h5A);
    check("b2b1_latency", done_at, EXP_LAT);
    check("b2b1_en",      en8,     8'b0000_0001);
    check("b2b1_ready",   ready8,  1);
    tick();
    check("b2b2_busy",  busy8,  1);
    check("b2b2_ready", ready8, 0);
    valid8 = 1'b0;
    run_op(-1, bits, rises, done_at, latch_cnt, blank_cnt, hold_bad, latch_bad);
    check("b2b2_bits",     bits,      8'hC3);
    check("b2b2_hold",     hold_bad,  0);
    check("b2b2_latchbad", latch_bad, 0);
    check("b2b2_latch",    latch_cnt, 2);
    check("b2b2_blank",    blank_cnt, EXP_BLANK);
    check("b2b2_latency",  done_at,   EXP_LAT);
    check("b2b2_en",       en8,       8'b1000_0000);

    // Six-layer instance: in range, then out of range clears the enables.
    run6(3'd5, lat6);
    check("oor_in_lat", lat6, EXP_LAT);
    check("oor_in_en",  en6,  6'b10_0000);
    run6(3'd7, lat6);
    check("oor_lat",   lat6,   EXP_LAT);
    check("oor_en",    en6,    6'b00_0000);
    check("oor_oe_n",  oe6,    0);
    check("oor_ready", ready6, 1);

    // Reset in the middle of a shift aborts immediately.
    data8 = 8'hFF; idx8 = 3'd1; valid8 = 1'b1;
    tick();
    valid8 = 1'b0;
    repeat (4) tick();
    check("mid_sr_clk_pre", sc8, 1);
    check("mid_en_pre",     en8, 8'b1000_0000);
    #2 rst = 1'b1;
    #1;
    check("mid_oe_n",   oe8,    1);
    check("mid_en",     en8,    0);
    check("mid_sr_clk", sc8,    0);
    check("mid_busy",   busy8,  0);
    check("mid_ready",  ready8, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    check("mid_rel_ready", ready8, 1);
    check("mid_rel_busy",  busy8,  0);
    n_done = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done8) n_done++;
    end
    check("mid_no_done", n_done, 0);
    check("mid_en_off",  en8,    0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
